// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the uart_tx arbiter: FSM encoding and the default
// settings used alongside uart_tx.
package uart_tx_arbiter_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd434;
  localparam int unsigned DEFAULT_LOCK_TIMEOUT = 32'd1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr,
// wrapping, returned both one-hot and as an index.
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic             found_s;
  logic             hit_s;
  logic [IDX_W-1:0] cand_s;

  assign any = |valid;

  // Scan requesters starting at ptr; the first valid one wins.
  always_comb begin
    grant   = {NUM_REQ{1'b0}};
    idx     = {IDX_W{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s        = IDX_W'((int'(ptr) + i) % NUM_REQ);
      hit_s         = !found_s && valid[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? cand_s : idx;
      found_s       = found_s | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters; a grant is held for a whole
// message and revoked if the owner stalls for LOCK_TIMEOUT cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_uart_char,
  output logic                 o_uart_write,
  input  logic                 i_uart_busy,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_timeout
);

  localparam int               IDX_W        = $clog2(NUM_REQ);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

  logic [2:0]         state_r;
  logic [NUM_REQ-1:0] grant_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [15:0]        cnt_r;
  logic [7:0]         hold_char_r;
  logic               hold_last_r;
  logic [7:0]         uart_char_r;
  logic               uart_write_r;
  logic               timeout_r;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic [NUM_REQ-1:0] ready_s;
  logic               handshake_s;
  logic [7:0]         sel_data_s;
  logic               sel_last_s;
  logic [IDX_W-1:0]   next_ptr_s;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid (i_req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Ready is combinational so a byte can be taken on the first SEND cycle.
  assign ready_s     = (state_r == S_SEND) ? (grant_r & i_req_valid) : {NUM_REQ{1'b0}};
  assign handshake_s = |ready_s;
  assign sel_data_s  = i_req_data[{owner_r, 3'b000} +: 8];
  assign sel_last_s  = i_req_last[owner_r];
  assign next_ptr_s  = (owner_r == LAST_IDX) ? {IDX_W{1'b0}} : owner_r + IDX_W'(1'b1);

  // Arbitration FSM, byte holding register, write strobe and lock timeout.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      grant_r      <= {NUM_REQ{1'b0}};
      owner_r      <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      cnt_r        <= 16'd0;
      hold_char_r  <= 8'd0;
      hold_last_r  <= 1'b0;
      uart_char_r  <= 8'd0;
      uart_write_r <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      uart_write_r <= 1'b0;
      timeout_r    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_any_s) begin
            grant_r <= pick_grant_s;
            owner_r <= pick_idx_s;
            cnt_r   <= 16'd0;
            state_r <= S_SEND;
          end
        end
        S_SEND: begin
          // A handshake on the expiry cycle still wins over the timeout.
          if (handshake_s) begin
            hold_char_r <= sel_data_s;
            hold_last_r <= sel_last_s;
            state_r     <= S_WRITE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            timeout_r <= 1'b1;
            grant_r   <= {NUM_REQ{1'b0}};
            rr_ptr_r  <= next_ptr_s;
            state_r   <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_WRITE: begin
          if (!i_uart_busy) begin
            uart_write_r <= 1'b1;
            uart_char_r  <= hold_char_r;
            state_r      <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_uart_busy) begin
            state_r <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_uart_busy) begin
            if (hold_last_r) begin
              grant_r  <= {NUM_REQ{1'b0}};
              rr_ptr_r <= next_ptr_s;
              state_r  <= S_IDLE;
            end else begin
              cnt_r   <= 16'd0;
              state_r <= S_SEND;
            end
          end
        end
        default: begin
          grant_r <= {NUM_REQ{1'b0}};
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = ready_s;
  assign o_uart_char  = uart_char_r;
  assign o_uart_write = uart_write_r;
  assign o_grant      = grant_r;
  assign o_timeout    = timeout_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model.
module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int LT       = 16;
  localparam int BUSY_CYC = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      uart_char;
  logic            uart_write;
  logic            uart_busy;
  logic [NREQ-1:0] grant;
  logic            timeout;
  logic            force_busy = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic       mbusy = 1'b0;
  int         mcnt = 0;
  logic       prev_wr = 1'b0;
  int         fall_cyc = 0;
  int         to_count = 0;
  int         to_delay = 0;
  int         b2b_viol = 0;
  int         multi_ready = 0;
  logic [7:0] wr_log[$];
  logic [3:0] gr_log[$];

  uart_tx_arbiter #(.NUM_REQ(NREQ), .LOCK_TIMEOUT(LT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_uart_char  (uart_char),
    .o_uart_write (uart_write),
    .i_uart_busy  (uart_busy),
    .o_grant      (grant),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign uart_busy = mbusy | force_busy;

  // uart_tx stand-in: busy for BUSY_CYC cycles after each strobe; also logs traffic
  always @(negedge clk) begin
    if (!rst_n) begin
      mbusy = 1'b0; mcnt = 0; prev_wr = 1'b0;
    end else begin
      if (uart_write) begin
        wr_log.push_back(uart_char);
        gr_log.push_back(grant);
        if (prev_wr) b2b_viol++;
        mbusy = 1'b1; mcnt = BUSY_CYC;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin mbusy = 1'b0; fall_cyc = cyc; end
      end
      prev_wr = uart_write;
      if (timeout) begin to_count++; to_delay = cyc - fall_cyc; end
      if ($countones(req_ready) > 1) multi_ready++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1);
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_last = '0; force_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk); #1;
      if (grant == 4'b0000 && !uart_busy) ok = 1'b1;
    end
  endtask

  task automatic send_msg(input int k, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic fin_last);
    for (int i = 0; i < n; i++) begin
      logic got;
      @(negedge clk);
      req_valid[k] = 1'b1;
      req_data[8*k +: 8] = (i == 0) ? b0 : b1;
      req_last[k] = (i == n - 1) ? fin_last : 1'b0;
      #1;
      got = 1'b0;
      for (int t = 0; t < 300 && !got; t++) begin
        if (req_ready[k]) got = 1'b1;
        else begin @(negedge clk); #1; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL handshake_req%0d: ready=0 after bound, want ready=1", k); end
      @(negedge clk);
      req_valid[k] = 1'b0; req_last[k] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (uart_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", uart_write); end
    checks++; if (uart_char !== 8'h00) begin errors++; $display("FAIL reset_char: got %h want 00", uart_char); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int base; int tb0; logic ok;
    base = wr_log.size(); tb0 = to_count;
    @(negedge clk);
    req_valid[0] = 1'b1; req_data[7:0] = 8'h41; req_last[0] = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    checks++; if (uart_write !== 1'b0) begin errors++; $display("FAIL single_write_early: got %b want 0", uart_write); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_write: got %b want 0000", req_ready); end
    @(negedge clk);
    checks++; if (uart_write !== 1'b1) begin errors++; $display("FAIL single_write_c3: got %b want 1", uart_write); end
    checks++; if (uart_char !== 8'h41) begin errors++; $display("FAIL single_char: got %h want 41", uart_char); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_release: grant=%b want 0000", grant); end
    checks++; if (wr_log.size() - base != 1) begin errors++; $display("FAIL single_strobes: got %0d want 1", wr_log.size() - base); end
    checks++; if (to_count != tb0) begin errors++; $display("FAIL single_timeout: got %0d want 0", to_count - tb0); end
  endtask

  task automatic test_round_robin;
    int base; logic ok;
    do_reset();
    base = wr_log.size();
    fork
      send_msg(0, 2, 8'h10, 8'h11, 1'b1);
      send_msg(2, 2, 8'h20, 8'h21, 1'b1);
    join
    wait_idle(ok);
    checks++; if (!ok || wr_log.size() != base + 4) begin errors++; $display("FAIL rr_count: got %0d want 4", wr_log.size() - base); end
    checks++; if (wr_log[base] !== 8'h10) begin errors++; $display("FAIL rr_byte0: got %h want 10", wr_log[base]); end
    checks++; if (wr_log[base+1] !== 8'h11) begin errors++; $display("FAIL rr_byte1: got %h want 11", wr_log[base+1]); end
    checks++; if (wr_log[base+2] !== 8'h20) begin errors++; $display("FAIL rr_byte2: got %h want 20", wr_log[base+2]); end
    checks++; if (wr_log[base+3] !== 8'h21) begin errors++; $display("FAIL rr_byte3: got %h want 21", wr_log[base+3]); end
    checks++; if (gr_log[base+1] !== 4'b0001 || gr_log[base+2] !== 4'b0100) begin
      errors++; $display("FAIL rr_owner: got %b,%b want 0001,0100", gr_log[base+1], gr_log[base+2]); end
    // pointer now 3: requester 3 must beat requester 0
    base = wr_log.size();
    fork
      send_msg(0, 1, 8'h30, 8'h00, 1'b1);
      send_msg(3, 1, 8'h33, 8'h00, 1'b1);
    join
    wait_idle(ok);
    checks++; if (wr_log[base] !== 8'h33) begin errors++; $display("FAIL rr_ptr_first: got %h want 33", wr_log[base]); end
    checks++; if (wr_log[base+1] !== 8'h30) begin errors++; $display("FAIL rr_ptr_second: got %h want 30", wr_log[base+1]); end
  endtask

  task automatic test_timeout;
    int base; int tb0; logic ok;
    base = wr_log.size(); tb0 = to_count;
    fork
      send_msg(1, 1, 8'h51, 8'h00, 1'b0);
      send_msg(3, 1, 8'h77, 8'h00, 1'b1);
    join
    wait_idle(ok);
    checks++; if (to_count - tb0 != 1) begin errors++; $display("FAIL to_pulses: got %0d want 1", to_count - tb0); end
    checks++; if (to_delay != LT + 1) begin errors++; $display("FAIL to_delay: got %0d want %0d", to_delay, LT + 1); end
    checks++; if (wr_log[base] !== 8'h51 || wr_log[base+1] !== 8'h77) begin
      errors++; $display("FAIL to_bytes: got %h,%h want 51,77", wr_log[base], wr_log[base+1]); end
    checks++; if (gr_log[base+1] !== 4'b1000) begin errors++; $display("FAIL to_next_owner: got %b want 1000", gr_log[base+1]); end
  endtask

  task automatic test_busy_stall;
    int base; logic ok;
    base = wr_log.size();
    @(negedge clk);
    force_busy = 1'b1;
    req_valid[2] = 1'b1; req_data[23:16] = 8'h5A; req_last[2] = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL stall_grant: got %b want 0100", grant); end
    @(negedge clk);
    req_valid[2] = 1'b0; req_last[2] = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (wr_log.size() != base) begin errors++; $display("FAIL stall_nostrobe: got %0d want 0", wr_log.size() - base); end
    force_busy = 1'b0;
    @(negedge clk);
    checks++; if (uart_write !== 1'b1 || uart_char !== 8'h5A) begin
      errors++; $display("FAIL stall_release: write=%b char=%h want 1,5a", uart_write, uart_char); end
    wait_idle(ok);
    checks++; if (wr_log.size() != base + 1) begin errors++; $display("FAIL stall_once: got %0d want 1", wr_log.size() - base); end
  endtask

  task automatic test_reset_mid;
    int base; logic ok;
    base = wr_log.size();
    send_msg(1, 1, 8'hC3, 8'h00, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); #1;
      if (wr_log.size() == base + 1) ok = 1'b1;
    end
    @(negedge clk);
    checks++; if (grant !== 4'b0010 || !uart_busy) begin
      errors++; $display("FAIL mid_pre: grant=%b busy=%b want 0010,1", grant, uart_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_async_grant: grant=%b ready=%b want 0000", grant, req_ready); end
    checks++; if (uart_write !== 1'b0 || uart_char !== 8'h00 || timeout !== 1'b0) begin
      errors++; $display("FAIL mid_async_out: write=%b char=%h to=%b want 0,00,0", uart_write, uart_char, timeout); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b1; req_data[15:8] = 8'h99; req_last[1] = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", grant); end
    @(negedge clk);
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    @(negedge clk);
    checks++; if (uart_write !== 1'b1 || uart_char !== 8'h99) begin
      errors++; $display("FAIL mid_write: write=%b char=%h want 1,99", uart_write, uart_char); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_release: grant=%b want 0000", grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_busy_stall();
    test_reset_mid();
    checks++; if (b2b_viol != 0) begin errors++; $display("FAIL write_b2b: got %0d want 0", b2b_viol); end
    checks++; if (multi_ready != 0) begin errors++; $display("FAIL ready_onehot: got %0d want 0", multi_ready); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter LOCK_TIMEOUT, default 1024: idle cycles a locked owner may stall before its lock is revoked; 16-bit counter.
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_req_valid  in  NUM_REQ  per-requester byte valid.
REQ-006 i_req_data  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 i_req_last  in  NUM_REQ  byte ends the requester's message.
REQ-008 o_req_ready  out  NUM_REQ  byte accepted this cycle; at most one bit set.
REQ-009 o_uart_char  out  8  byte to uart_tx i_char.
REQ-010 o_uart_write  out  1  one-cycle write strobe to uart_tx i_write.
REQ-011 i_uart_busy  in  1  uart_tx o_busy.
REQ-012 o_grant  out  NUM_REQ  one-hot current owner; all-zero when no owner.
REQ-013 o_timeout  out  1  one-cycle pulse when a lock is revoked.

Function
REQ-014 States: IDLE, SEND, WRITE, WAIT_ACK, WAIT_DONE.
REQ-015 IDLE: if any i_req_valid, grant the first valid requester at or after rr_ptr (wrapping), register o_grant, go to SEND next cycle; else stay.
REQ-016 SEND: o_req_ready[owner] = i_req_valid[owner] (combinational); on that handshake, capture the byte into hold_char, capture last into hold_last, go to WRITE.
REQ-017 WRITE: while i_uart_busy=1, hold; when i_uart_busy=0, drive o_uart_write=1 with o_uart_char=hold_char for exactly one cycle, go to WAIT_ACK.
REQ-018 WAIT_ACK: wait for i_uart_busy=1, then go to WAIT_DONE; o_uart_write=0 throughout.
REQ-019 WAIT_DONE: wait for i_uart_busy=0; then if hold_last=1, clear o_grant, set rr_ptr=(owner+1) mod NUM_REQ, and go to IDLE; else return to SEND.
REQ-020 The grant is locked for the whole message: no other requester is granted until the owner's last byte has fully transmitted.
REQ-021 Timeout counter clears on entry to SEND and increments each SEND cycle without a handshake.
REQ-022 When the counter reaches LOCK_TIMEOUT-1 in SEND: pulse o_timeout, clear o_grant, advance rr_ptr past the owner, go to IDLE.
REQ-023 A handshake on the same cycle as expiry takes priority; no timeout occurs.
REQ-024 o_uart_write is registered and never asserts on two consecutive cycles.
REQ-025 At most one byte is outstanding; no byte is accepted from SEND until the previous byte's busy period has ended.
REQ-026 o_req_ready is 0 in every state other than SEND, and 0 for non-owners.
REQ-027 Valid deasserted by a requester before a handshake drops no data; the arbiter requires no stability of valid.
REQ-028 Latency: with an idle UART, a byte presented in IDLE produces o_uart_write 3 cycles after valid rises (IDLE, SEND, WRITE).

Reset
REQ-029 While i_rst_n=0, immediately: state=IDLE, o_grant=0, o_req_ready=0, o_uart_write=0, o_uart_char=0, o_timeout=0, rr_ptr=0, timeout counter=0.
REQ-030 Reset asserted mid-transfer abandons the byte; the first cycle after release behaves as IDLE with rr_ptr=0.

Structure
REQ-031 A shared package holds the state encoding constants and the default CLKS_PER_BIT/LOCK_TIMEOUT values used with uart_tx.
REQ-032 One sub-module, rr_pick: combinational round-robin selector (valid vector, pointer) -> one-hot grant plus index.

Verification
REQ-033 Requester 0 sends 0x41 with last=1, UART idle -> o_uart_write at cycle 3 with o_uart_char=0x41; o_grant=0 after busy falls.
REQ-034 Requesters 0 and 2 both valid, 2-byte messages -> all bytes of requester 0 are transmitted before any byte of requester 2; rr_ptr then equals 3.
REQ-035 Owner 1 stops after a non-last byte while requester 3 waits -> o_timeout pulses after LOCK_TIMEOUT cycles; requester 3 is granted next.
REQ-036 i_uart_busy held at 1 at grant time -> WRITE stalls with no strobe until busy falls; then exactly one strobe.
REQ-037 Reset asserted during WAIT_DONE -> all outputs 0 asynchronously; after release, a new request from requester 1 is granted normally.
